pulse_phase_gen: RTL and testbench

PULSE_PHASE_GEN -- requirements
Module: pulse_phase_gen

---
 rtl/pulse_phase_gen.sv | 152 +++++++++++++++
 tb/tb_pulse_phase_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_phase_gen.sv
// Phase sequencer for downstream switch drivers: IDLE -> PRE -> MAIN -> END.
// Define PULSE_REPEAT_EN to add cfg_rep (extra PRE/MAIN repetitions before END).
module pulse_phase_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_state,
    input  logic        start,
    input  logic [7:0]  cfg_pre,
    input  logic [15:0] cfg_main,
`ifdef PULSE_REPEAT_EN
    input  logic [3:0]  cfg_rep,
`endif
    output logic [1:0]  pulse_state,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_MAIN = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_main;

    logic [1:0]  w_nxt_state;
    logic [15:0] w_nxt_cnt;
    logic        w_ld_cfg;
    logic [15:0] w_cfg_pre_m1;
    logic [15:0] w_cfg_main_m1;
    logic [15:0] w_main_m1;

`ifdef PULSE_REPEAT_EN
    logic [7:0]  r_pre;
    logic [3:0]  r_rep;
    logic [3:0]  w_nxt_rep;
    logic [15:0] w_pre_m1;

    assign w_pre_m1 = {8'd0, r_pre} - 16'd1;
`endif

    // Phase lengths minus one; a zero MAIN length is run as a single cycle.
    assign w_cfg_pre_m1  = {8'd0, cfg_pre} - 16'd1;
    assign w_cfg_main_m1 = (cfg_main == 16'd0) ? 16'd0 : cfg_main - 16'd1;
    assign w_main_m1     = (r_main == 16'd0) ? 16'd0 : r_main - 16'd1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_ld_cfg    = 1'b0;
`ifdef PULSE_REPEAT_EN
        w_nxt_rep   = r_rep;
`endif
        if (!key_state) begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_ld_cfg = 1'b1;
`ifdef PULSE_REPEAT_EN
                        w_nxt_rep = cfg_rep;
`endif
                        if (cfg_pre != 8'd0) begin
                            w_nxt_state = ST_PRE;
                            w_nxt_cnt   = w_cfg_pre_m1;
                        end else begin
                            w_nxt_state = ST_MAIN;
                            w_nxt_cnt   = w_cfg_main_m1;
                        end
                    end
                end
                ST_PRE: begin
                    if (r_cnt == 16'd0) begin
                        w_nxt_state = ST_MAIN;
                        w_nxt_cnt   = w_main_m1;
                    end else begin
                        w_nxt_cnt = r_cnt - 16'd1;
                    end
                end
                ST_MAIN: begin
                    if (r_cnt == 16'd0) begin
                        w_nxt_state = ST_END;
                        w_nxt_cnt   = 16'd0;
`ifdef PULSE_REPEAT_EN
                        // Another pass pending: go round again instead of ending.
                        if (r_rep != 4'd0) begin
                            w_nxt_rep = r_rep - 4'd1;
                            if (r_pre != 8'd0) begin
                                w_nxt_state = ST_PRE;
                                w_nxt_cnt   = w_pre_m1;
                            end else begin
                                w_nxt_state = ST_MAIN;
                                w_nxt_cnt   = w_main_m1;
                            end
                        end
`endif
                    end else begin
                        w_nxt_cnt = r_cnt - 16'd1;
                    end
                end
                ST_END: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = 16'd0;
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    // In the single-shot build the PRE length only matters at entry, where it
    // goes straight into the counter, so only MAIN needs a shadow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= 16'd0;
        end else if (w_ld_cfg) begin
            r_main <= cfg_main;
        end
    end

`ifdef PULSE_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= 8'd0;
            r_rep <= 4'd0;
        end else begin
            if (w_ld_cfg) r_pre <= cfg_pre;
            r_rep <= w_nxt_rep;
        end
    end
`endif

    assign pulse_state = r_state;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_END);

endmodule

// File: tb/tb_pulse_phase_gen.sv
// Directed bench for pulse_phase_gen with a queue-based phase model checked every cycle.
module tb_pulse_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_state = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_pre = 8'd0;
    logic [15:0] cfg_main = 16'd0;
    logic [3:0]  cfg_rep = 4'd0;
    logic [1:0]  pulse_state;
    logic        busy;
    logic        done;

`ifdef PULSE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pulse_phase_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_state  (key_state),
        .start      (start),
        .cfg_pre    (cfg_pre),
        .cfg_main   (cfg_main),
`ifdef PULSE_REPEAT_EN
        .cfg_rep    (cfg_rep),
`endif
        .pulse_state(pulse_state),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the whole sequence of phase codes is queued at start; one per cycle.
    int q[$];

    function automatic void build(input int pre, input int main, input int rep);
        int mlen;
        mlen = (main == 0) ? 1 : main;
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < pre; i++) q.push_back(1);
            for (int i = 0; i < mlen; i++) q.push_back(2);
        end
        q.push_back(3);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (!key_state) q.delete();
        else if (q.size() == 0) begin
            if (start) build(int'(cfg_pre), int'(cfg_main), REP_EN ? int'(cfg_rep) : 0);
        end else void'(q.pop_front());
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int exp;
            exp = (q.size() != 0) ? q[0] : 0;
            check("pulse_state", int'(pulse_state), exp);
            check("busy", int'(busy), (exp != 0) ? 1 : 0);
            check("done", int'(done), (exp == 3) ? 1 : 0);
        end
    end

    task automatic run(input int pre, input int main, input int rep,
                       input int poke_at, input int drop_at, input int max_cyc,
                       output int n1, output int n2, output int n3,
                       output int nd, output int nb);
        bit seen;
        bit fin;
        n1 = 0; n2 = 0; n3 = 0; nd = 0; nb = 0;
        seen = 1'b0; fin = 1'b0;
        @(negedge clk);
        key_state = 1'b1;
        cfg_pre   = pre[7:0];
        cfg_main  = main[15:0];
        cfg_rep   = rep[3:0];
        start     = 1'b1;
        for (int i = 1; i <= max_cyc && !fin; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (pulse_state == 2'd1) n1++;
            if (pulse_state == 2'd2) n2++;
            if (pulse_state == 2'd3) n3++;
            nd += int'(done);
            nb += int'(busy);
            if (busy) seen = 1'b1;
            else if (seen) fin = 1'b1;
            if (i == poke_at) begin
                start    = 1'b1;
                cfg_main = 16'd100;
            end
            if (i == drop_at) key_state = 1'b0;
        end
        if (!fin) check("timeout_idle", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2, n3, nd, nb;

        // Reset state
        #1 rst_n = 1'b0;
        #20;
        check("rst_pulse_state", int'(pulse_state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic sequence
        run(3, 5, 0, 0, 0, 40, n1, n2, n3, nd, nb);
        check("basic_pre", n1, 3);
        check("basic_main", n2, 5);
        check("basic_end", n3, 1);
        check("basic_done", nd, 1);
        check("basic_busy", nb, 9);

        // Zero lengths
        run(0, 0, 0, 0, 0, 40, n1, n2, n3, nd, nb);
        check("zero_pre", n1, 0);
        check("zero_main", n2, 1);
        check("zero_end", n3, 1);
        check("zero_busy", nb, 2);

        // Restart and cfg_main change during MAIN
        run(2, 10, 0, 5, 0, 60, n1, n2, n3, nd, nb);
        check("busychg_main", n2, 10);
        check("busychg_busy", nb, 13);
        check("busychg_done", nd, 1);
        repeat (5) @(negedge clk);
        check("busychg_no_second", int'(pulse_state), 0);
        cfg_main = 16'd0;

        // Abort in second MAIN cycle, then a normal run
        run(1, 6, 0, 0, 3, 40, n1, n2, n3, nd, nb);
        check("abort_pre", n1, 1);
        check("abort_main", n2, 2);
        check("abort_end", n3, 0);
        check("abort_done", nd, 0);
        run(1, 2, 0, 0, 0, 40, n1, n2, n3, nd, nb);
        check("post_abort_main", n2, 2);
        check("post_abort_done", nd, 1);
        check("post_abort_busy", nb, 4);

        // Asynchronous reset during PRE
        @(negedge clk);
        key_state = 1'b1; cfg_pre = 8'd5; cfg_main = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_pulse_state", int'(pulse_state), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_idle", int'(pulse_state), 0);
        run(3, 5, 0, 0, 0, 40, n1, n2, n3, nd, nb);
        check("midrst_rerun_busy", nb, 9);

        // Repetition count (ignored in the single-shot build)
        run(2, 4, 2, 0, 0, 80, n1, n2, n3, nd, nb);
`ifdef PULSE_REPEAT_EN
        check("rep_pre", n1, 6);
        check("rep_main", n2, 12);
        check("rep_end", n3, 1);
        check("rep_done", nd, 1);
        check("rep_busy", nb, 19);
`else
        check("norep_pre", n1, 2);
        check("norep_main", n2, 4);
        check("norep_done", nd, 1);
        check("norep_busy", nb, 7);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
